// File: rtl/palindrome_pkg.sv
// -----------------------------------------------------------------------------
// palindrome_pkg
// Shared definitions for the palindrome check scheduler and its round-robin
// picker.
//   state_t             : scheduler FSM states (IDLE, WAIT)
//   DEFAULT_DATA_W      : default width of the checked word
//   DEFAULT_DET_LATENCY : default detector register stages, data_in -> result
//   id_width()          : width of a requester index, never below 1 bit
// -----------------------------------------------------------------------------
package palindrome_pkg;

  localparam int DEFAULT_DATA_W      = 8;
  localparam int DEFAULT_DET_LATENCY = 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // A single requester would still need a 1-bit ID port.
  function automatic int id_width(input int num_req);
    return (num_req > 2) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/palindrome_check_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req_i starting at ptr_i and
// wrapping modulo NUM_REQ; the first set bit found is the grant.
//   req_i     : request vector, one bit per requester
//   ptr_i     : index with highest priority this round (must be < NUM_REQ)
//   grant_o   : index of the chosen requester (0 when no request is set)
//   any_req_o : at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick
  import palindrome_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [ID_W-1:0]    grant_o,
  output logic               any_req_o
);

  // Candidate gi is the requester sitting gi places after ptr_i, so lower gi
  // means higher priority.
  logic [ID_W-1:0]    cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    // One extra bit holds ptr + offset before the modulo wrap; the sum never
    // exceeds 2*NUM_REQ-2, which fits because NUM_REQ <= 2**ID_W.
    logic [ID_W:0] sum;
    assign sum          = {1'b0, ptr_i} + (ID_W+1)'(gi);
    assign cand_idx[gi] = (sum >= (ID_W+1)'(NUM_REQ))
                          ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                          : sum[ID_W-1:0];
    assign cand_hit[gi] = req_i[cand_idx[gi]];
  end

  // Scan from lowest priority to highest so the nearest hit after ptr_i wins.
  always_comb begin
    grant_o   = '0;
    any_req_o = |req_i;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        grant_o = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/palindrome_check_scheduler.sv
// -----------------------------------------------------------------------------
// palindrome_check_scheduler
// Shares a single external palindrome detector among NUM_REQ requesters.
// A round-robin grant loads the chosen word into det_data, the scheduler waits
// out the detector latency, then returns the verdict tagged with the requester
// ID and updates two saturating statistics counters.
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   req, req_data   : per-requester request level and packed words
//   ack             : one-hot, one-cycle grant pulse
//   det_data        : registered word driven to the detector's data_in
//   det_result      : detector is_palindrome, sampled on one edge only
//   rsp_valid       : one-cycle verdict pulse; rsp_id / rsp_palindrome qualify it
//   busy            : high while a check is in flight
//   checks_done     : saturating count of completed checks
//   pal_hits        : saturating count of palindromic verdicts
// -----------------------------------------------------------------------------
module palindrome_check_scheduler
  import palindrome_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_W      = DEFAULT_DATA_W,
  parameter  int DET_LATENCY = DEFAULT_DET_LATENCY,
  parameter  int CNT_W       = 16,
  localparam int ID_W        = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         det_data,
  input  logic                      det_result,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_palindrome,
  output logic                      busy,
  output logic [CNT_W-1:0]          checks_done,
  output logic [CNT_W-1:0]          pal_hits
);

  // The wait counter is loaded with DET_LATENCY+1 and the verdict is taken on
  // the edge where it reads 1.
  localparam int WCNT_W = $clog2(DET_LATENCY + 2);
  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(DET_LATENCY + 1);

  state_t              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     grant_id_q;
  logic [WCNT_W-1:0]   wait_cnt_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [DATA_W-1:0]   det_data_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic                rsp_pal_q;
  logic [CNT_W-1:0]    checks_q;
  logic [CNT_W-1:0]    hits_q;

  logic [ID_W-1:0]     pick_grant;
  logic                pick_any;
  logic [ID_W-1:0]     ptr_d;
  logic [NUM_REQ-1:0]  ack_d;
  logic [DATA_W-1:0]   word_d;
  logic [CNT_W-1:0]    checks_d;
  logic [CNT_W-1:0]    hits_d;

  // Unpack the flat request bus so the granted word is a plain array lookup.
  logic [DATA_W-1:0] word_arr [NUM_REQ];
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign word_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .grant_o   (pick_grant),
    .any_req_o (pick_any)
  );

  always_comb begin
    ptr_d    = (pick_grant == ID_W'(NUM_REQ - 1)) ? '0 : pick_grant + 1'b1;
    ack_d    = NUM_REQ'(1) << pick_grant;
    word_d   = word_arr[pick_grant];
    // Both counters stick at all-ones instead of wrapping.
    checks_d = (checks_q == '1) ? checks_q : checks_q + 1'b1;
    hits_d   = (det_result && (hits_q != '1)) ? hits_q + 1'b1 : hits_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_id_q  <= '0;
      wait_cnt_q  <= '0;
      ack_q       <= '0;
      det_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_pal_q   <= 1'b0;
      checks_q    <= '0;
      hits_q      <= '0;
    end else begin
      // Both pulses are single-cycle; they are only raised below.
      ack_q       <= '0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            det_data_q <= word_d;
            ack_q      <= ack_d;
            grant_id_q <= pick_grant;
            ptr_q      <= ptr_d;
            wait_cnt_q <= WAIT_LOAD;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          // Requests are not looked at here, so a second ack cannot be issued
          // before this check's verdict has gone out.
          if (wait_cnt_q == WCNT_W'(1)) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= grant_id_q;
            rsp_pal_q   <= det_result;
            checks_q    <= checks_d;
            hits_q      <= hits_d;
            wait_cnt_q  <= '0;
            state_q     <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack            = ack_q;
  assign det_data       = det_data_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_id         = rsp_id_q;
  assign rsp_palindrome = rsp_pal_q;
  assign busy           = (state_q != IDLE);
  assign checks_done    = checks_q;
  assign pal_hits       = hits_q;

endmodule

// File: tb/tb_palindrome_check_scheduler.sv
module tb_palindrome_check_scheduler;
  import palindrome_pkg::*;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 8;
  localparam int DET_LATENCY = 1;
  localparam int CNT_W       = 16;
  localparam int SAT_W       = 3;
  localparam int ID_W        = id_width(NUM_REQ);
  localparam int CMAX        = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         det_data;
  logic                      det_result;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic                      rsp_palindrome;
  logic                      busy;
  logic [CNT_W-1:0]          checks_done;
  logic [CNT_W-1:0]          pal_hits;

  // Narrow-counter instance for saturation
  logic [NUM_REQ-1:0]        sat_req;
  logic [NUM_REQ*DATA_W-1:0] sat_data;
  logic [NUM_REQ-1:0]        sat_ack;
  logic [DATA_W-1:0]         sat_det_data;
  logic                      sat_det_result;
  logic                      sat_rsp_valid;
  logic [ID_W-1:0]           sat_rsp_id;
  logic                      sat_rsp_pal;
  logic                      sat_busy;
  logic [SAT_W-1:0]          sat_checks;
  logic [SAT_W-1:0]          sat_hits;

  palindrome_check_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DET_LATENCY(DET_LATENCY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .det_data(det_data), .det_result(det_result), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_palindrome(rsp_palindrome), .busy(busy),
    .checks_done(checks_done), .pal_hits(pal_hits)
  );

  palindrome_check_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DET_LATENCY(DET_LATENCY), .CNT_W(SAT_W)
  ) dut_sat (
    .clk(clk), .rst(rst), .req(sat_req), .req_data(sat_data), .ack(sat_ack),
    .det_data(sat_det_data), .det_result(sat_det_result), .rsp_valid(sat_rsp_valid),
    .rsp_id(sat_rsp_id), .rsp_palindrome(sat_rsp_pal), .busy(sat_busy),
    .checks_done(sat_checks), .pal_hits(sat_hits)
  );

  function automatic logic is_pal(input logic [DATA_W-1:0] w);
    for (int i = 0; i < DATA_W / 2; i++) begin
      if (w[i] != w[DATA_W-1-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int rr_model(input logic [NUM_REQ-1:0] r, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return 0;
  endfunction

  function automatic logic [DATA_W-1:0] word_at(input logic [NUM_REQ*DATA_W-1:0] d, input int g);
    return d[g*DATA_W +: DATA_W];
  endfunction

  // One-stage palindrome detectors attached to each instance
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      det_result     <= 1'b0;
      sat_det_result <= 1'b0;
    end else begin
      det_result     <= is_pal(det_data);
      sat_det_result <= is_pal(sat_det_data);
    end
  end

  // Transaction-level model of the main instance: a grant at edge c yields
  // its verdict (computed from the data word) at edge c+DET_LATENCY+1.
  int                 m_cycle;
  int                 m_rsp_edge;
  int                 m_ptr;
  logic               m_idle;
  int                 m_pend_id;
  logic               m_pend_pal;
  logic [NUM_REQ-1:0] e_ack;
  logic [DATA_W-1:0]  e_det;
  logic               e_rv;
  int                 e_id;
  logic               e_pal;
  int                 e_checks;
  int                 e_hits;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cycle <= 0; m_rsp_edge <= 0; m_ptr <= 0; m_idle <= 1'b1;
      m_pend_id <= 0; m_pend_pal <= 1'b0;
      e_ack <= '0; e_det <= '0; e_rv <= 1'b0; e_id <= 0; e_pal <= 1'b0;
      e_checks <= 0; e_hits <= 0;
    end else begin
      m_cycle <= m_cycle + 1;
      e_ack   <= '0;
      e_rv    <= 1'b0;
      if (!m_idle) begin
        if (m_cycle == m_rsp_edge) begin
          e_rv     <= 1'b1;
          e_id     <= m_pend_id;
          e_pal    <= m_pend_pal;
          e_checks <= (e_checks < CMAX) ? e_checks + 1 : e_checks;
          e_hits   <= (m_pend_pal && e_hits < CMAX) ? e_hits + 1 : e_hits;
          m_idle   <= 1'b1;
        end
      end else if (req != '0) begin
        e_ack      <= NUM_REQ'(1) << rr_model(req, m_ptr);
        e_det      <= word_at(req_data, rr_model(req, m_ptr));
        m_pend_id  <= rr_model(req, m_ptr);
        m_pend_pal <= is_pal(word_at(req_data, rr_model(req, m_ptr)));
        m_ptr      <= (rr_model(req, m_ptr) + 1) % NUM_REQ;
        m_rsp_edge <= m_cycle + DET_LATENCY + 1;
        m_idle     <= 1'b0;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle and compare the main instance against the model.
  task automatic tick();
    @(negedge clk);
    chk("m_ack", ack, e_ack);
    chk("m_det_data", det_data, e_det);
    chk("m_rsp_valid", rsp_valid, e_rv);
    chk("m_busy", busy, !m_idle);
    chk("m_checks_done", checks_done, e_checks);
    chk("m_pal_hits", pal_hits, e_hits);
    if (e_rv) begin
      chk("m_rsp_id", rsp_id, e_id);
      chk("m_rsp_pal", rsp_palindrome, e_pal);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_det"}, det_data, 0);
    chk({tag, "_rv"}, rsp_valid, 0);
    chk({tag, "_id"}, rsp_id, 0);
    chk({tag, "_pal"}, rsp_palindrome, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_checks"}, checks_done, 0);
    chk({tag, "_hits"}, pal_hits, 0);
  endtask

  logic [DATA_W-1:0]  rr_words [4] = '{8'b11001101, 8'b11011011, 8'b10101010, 8'b11110000};
  logic               rr_verd  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  int                 rr_hits  [5] = '{0, 1, 1, 1, 1};
  logic [NUM_REQ-1:0] exp_oh;

  initial begin
    req = '0; req_data = '0; sat_req = '0; sat_data = '0;

    // Test 1: reset state, then idle with no requests
    tick(); tick();
    check_all_zero("t1_rst");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t1_idle_busy", busy, 0);
      chk("t1_idle_ack", ack, 0);
    end

    // Test 2: single request, latency and verdict
    req_data[0 +: DATA_W] = 8'b00111100;
    req = 4'b0001;
    tick();
    chk("t2_ack", ack, 4'b0001);
    chk("t2_det", det_data, 8'b00111100);
    req = '0;
    tick();
    chk("t2_ack_drop", ack, 0);
    chk("t2_rv_early", rsp_valid, 0);
    tick();
    chk("t2_rv", rsp_valid, 1);
    chk("t2_id", rsp_id, 0);
    chk("t2_pal", rsp_palindrome, 1);
    chk("t2_checks", checks_done, 1);
    chk("t2_hits", pal_hits, 1);
    tick();
    chk("t2_rv_drop", rsp_valid, 0);

    // Test 5: reset mid-WAIT aborts; re-issued request completes
    req_data[1*DATA_W +: DATA_W] = 8'b10000001;
    req = 4'b0010;
    tick();
    chk("t5_ack", ack, 4'b0010);
    req = '0;
    tick();
    chk("t5_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    check_all_zero("t5_async");
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_rv", rsp_valid, 0);
      chk("t5_checks0", checks_done, 0);
    end
    req = 4'b0010;
    tick();
    chk("t5_reack", ack, 4'b0010);
    req = '0;
    tick(); tick();
    chk("t5_rv", rsp_valid, 1);
    chk("t5_id", rsp_id, 1);
    chk("t5_pal", rsp_palindrome, 1);
    chk("t5_checks", checks_done, 1);

    // Reset pulse so round-robin starts at requester 0
    rst = 1'b1;
    #1;
    chk("rst2_checks", checks_done, 0);
    tick();
    rst = 1'b0;

    // Test 3: round-robin with all requests held
    for (int i = 0; i < 4; i++) req_data[i*DATA_W +: DATA_W] = rr_words[i];
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_oh = 4'b0001 << (k % 4);
      chk("t3_ack", ack, exp_oh);
      tick(); tick();
      chk("t3_rv", rsp_valid, 1);
      chk("t3_id", rsp_id, k % 4);
      chk("t3_pal", rsp_palindrome, rr_verd[k % 4]);
      chk("t3_hits", pal_hits, rr_hits[k]);
    end
    req = '0;
    chk("t3_checks", checks_done, 5);

    // Test 4: wrap and skip (ptr is 1 here)
    req = 4'b0100;
    tick(); chk("t4_ack_a", ack, 4'b0100);
    req = '0;
    tick(); tick(); chk("t4_id_a", rsp_id, 2);
    req = 4'b0011;
    tick(); chk("t4_ack_b", ack, 4'b0001);
    tick(); tick(); chk("t4_id_b", rsp_id, 0);
    tick(); chk("t4_ack_c", ack, 4'b0010);
    req = '0;
    tick(); tick(); chk("t4_id_c", rsp_id, 1);
    req = 4'b0100;
    tick(); chk("t4_ack_d", ack, 4'b0100);
    req = '0;
    tick(); tick(); chk("t4_id_d", rsp_id, 2);
    tick();

    // Test 6: saturation on the 3-bit counter instance
    sat_data[0 +: DATA_W] = 8'b11011011;
    for (int i = 1; i <= 9; i++) begin
      sat_req = 4'b0001;
      tick();
      chk("t6_ack", sat_ack, 4'b0001);
      sat_req = '0;
      tick(); tick();
      chk("t6_rv", sat_rsp_valid, 1);
      chk("t6_checks", sat_checks, (i < 7) ? i : 7);
      chk("t6_hits", sat_hits, (i < 7) ? i : 7);
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
